// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an instruction
// fetch port and a load/store port. Each transaction goes IDLE -> ACCESS ->
// WAIT -> IDLE. LATENCY is the number of cycles from mem_en to valid
// mem_rdata (1..7).
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the two ports. When it is not defined, the data
// port always wins.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT_C = 3'(LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      stateNext_s;
    logic [2:0]  cnt_r;
    logic        anyReq_s;
    logic        selData_s;
    logic        lastDone_s;
    logic        ownerData_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        ifGnt_r;
    logic        dGnt_r;
    logic        ifRvalid_r;
    logic        dRvalid_r;
    logic [31:0] ifRdata_r;
    logic [31:0] dRdata_r;
    logic        memEn_r;
    logic        memWe_r;

    assign anyReq_s   = if_req | d_req;
    assign lastDone_s = (state_r == WAIT) && (cnt_r == LAT_C);

`ifdef ARB_ROUND_ROBIN_EN
    logic lastOwner_r;  // 1 = data port owned the most recent access

    // Remember which port was selected last so that contention alternates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastOwner_r <= 1'b0;
        end else if ((state_r == IDLE) && anyReq_s) begin
            lastOwner_r <= selData_s;
        end
    end

    // Owner choice: under contention, give the access to the port that did not own the last one.
    always_comb begin
        selData_s = 1'b0;
        if (d_req && if_req) begin
            selData_s = ~lastOwner_r;
        end else if (d_req) begin
            selData_s = 1'b1;
        end else begin
            selData_s = 1'b0;
        end
    end
`else
    // Owner choice: the data port always beats instruction fetch.
    always_comb begin
        selData_s = 1'b0;
        if (d_req) begin
            selData_s = 1'b1;
        end else begin
            selData_s = 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic. A request that is withdrawn before IDLE samples it is never seen.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (anyReq_s) begin
                    stateNext_s = ACCESS;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ACCESS: stateNext_s = WAIT;
            WAIT: begin
                if (lastDone_s) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = WAIT;
                end
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // Datapath: latch the request, time the memory latency, and register every output pulse and data word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= 3'd0;
            ownerData_r <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            ifGnt_r     <= 1'b0;
            dGnt_r      <= 1'b0;
            ifRvalid_r  <= 1'b0;
            dRvalid_r   <= 1'b0;
            ifRdata_r   <= 32'd0;
            dRdata_r    <= 32'd0;
            memEn_r     <= 1'b0;
            memWe_r     <= 1'b0;
        end else begin
            if ((state_r == IDLE) && anyReq_s) begin
                ownerData_r <= selData_s;
                we_r        <= selData_s & d_we;
                addr_r      <= selData_s ? d_addr : if_addr;
                wdata_r     <= selData_s ? d_wdata : 32'd0;
            end

            // The counter is 1 in the first WAIT cycle, so it equals LATENCY in the cycle where the data is valid.
            if (state_r == ACCESS) begin
                cnt_r <= 3'd1;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= 3'd0;
            end

            memEn_r <= (stateNext_s == ACCESS);
            memWe_r <= (stateNext_s == ACCESS) && selData_s && d_we;
            ifGnt_r <= (stateNext_s == ACCESS) && !selData_s;
            dGnt_r  <= (stateNext_s == ACCESS) && selData_s;

            ifRvalid_r <= lastDone_s && !ownerData_r;
            dRvalid_r  <= lastDone_s && ownerData_r;
            if (lastDone_s && !ownerData_r) begin
                ifRdata_r <= mem_rdata;
            end
            // A store completes with a valid pulse, but d_rdata keeps its old contents.
            if (lastDone_s && ownerData_r && !we_r) begin
                dRdata_r <= mem_rdata;
            end
        end
    end

    assign if_gnt    = ifGnt_r;
    assign d_gnt     = dGnt_r;
    assign if_rvalid = ifRvalid_r;
    assign d_rvalid  = dRvalid_r;
    assign if_rdata  = ifRdata_r;
    assign d_rdata   = dRdata_r;
    assign mem_en    = memEn_r;
    assign mem_we    = memWe_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..7.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch word address
- if_gnt  out  1  fetch request accepted, one-cycle pulse
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetch data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted, one-cycle pulse
- d_rvalid  out  1  load data valid or store done, one-cycle pulse
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  arbiter not in IDLE

Function
REQ-003 SHALL implement an FSM with states IDLE, ACCESS and WAIT; busy = (state != IDLE).
REQ-004 In IDLE with at least one req high, SHALL select an owner, latch its address, write data and we, and enter ACCESS next cycle; with no req, SHALL stay in IDLE.
REQ-005 In ACCESS, SHALL drive mem_en=1, mem_we = latched we (0 for fetch), and latched addr/wdata, and SHALL pulse the owner's gnt for exactly this one cycle, then enter WAIT.
REQ-006 In WAIT, SHALL count LATENCY cycles from the ACCESS cycle, sample mem_rdata in the cycle it is valid, and pulse the owner's rvalid on the following cycle with rdata equal to the sampled value.
REQ-007 SHALL return to IDLE in the rvalid cycle; a pending request SHALL be selected in the IDLE cycle that follows, so issue-to-issue spacing is LATENCY+2 cycles.
REQ-008 For stores, d_rvalid SHALL pulse with the same timing as loads; d_rdata SHALL hold its previous value.
REQ-009 if_rdata and d_rdata SHALL hold their values until the next rvalid of the same port.
REQ-010 A req deasserted before selection in IDLE SHALL cause no access; a req deasserted after selection SHALL NOT abort the access.
REQ-011 Outside ACCESS, mem_en and mem_we SHALL be 0; gnt and rvalid SHALL never be high for both ports in the same cycle.
REQ-012 Default arbitration: if_req and d_req both high in IDLE SHALL select data.

Reset
REQ-013 reset SHALL force state IDLE, counter 0, all gnt/rvalid/mem_en/mem_we/busy = 0, rdata and mem_addr/mem_wdata = 0.
REQ-014 reset during ACCESS or WAIT SHALL abort the access with no rvalid pulse after reset release.

Configuration
REQ-015 With ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL go to the port not granted most recently; last-owner is 0 (fetch) after reset, so data wins first.
REQ-016 Without ARB_ROUND_ROBIN_EN, the fixed data-priority rule of REQ-012 SHALL apply, and the last-owner register SHALL not exist.

Verification
REQ-017 Single fetch, LATENCY=2: if_req, if_addr=0x10 in cycle 0; memory returns 0x00500093 -> if_gnt in cycle 1 with mem_addr=0x10; if_rvalid in cycle 4 with if_rdata=0x00500093.
REQ-018 Store: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> ACCESS with mem_we=1, mem_wdata=0xDEADBEEF; d_rvalid 3 cycles after d_gnt; d_rdata unchanged.
REQ-019 Contention, both req held high for 4 transactions: without macro, d_gnt every grant and no if_gnt; with ARB_ROUND_ROBIN_EN, grants go D, I, D, I, spaced 4 cycles apart.
REQ-020 Reset asserted in the WAIT cycle of a load -> all outputs 0 immediately; no rvalid afterwards; next request served normally.
REQ-021 Withdrawn request: d_req pulsed for one cycle while busy -> no d_gnt and no memory access.
